// File: rtl/psram_arbiter.sv
// psram_arbiter: grants the PSRAM engine to either the read-refill port or the MCU write port,
// round-robin when both request, and sequences start / busy / done / inter-transaction gap.
// Optional feature macro PSRAM_ARB_URGENT_EN: an urgent read beats a pending write in IDLE.
module psram_arbiter #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned LEN_W      = 6,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              rd_urgent,
  output logic              rd_ack,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_ack,
  output logic              wr_done,
  output logic              eng_start,
  output logic              eng_write,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [LEN_W-1:0]  eng_len,
  input  logic              eng_done,
  output logic              eng_busy,
  output logic              err_timeout
);

  typedef enum logic [2:0] {StInit, StIdle, StIssue, StBusy, StGap} state_e;

  // Counters start at 0 on state entry, so the last cycle of a phase sees count N-1.
  localparam logic [15:0] BusyLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] GapLast  = 16'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       cnt_inc;
  logic              urgent_win;
  logic              grant_rd;

`ifdef PSRAM_ARB_URGENT_EN
  assign urgent_win = rd_urgent;
`else
  logic unused_rd_urgent;
  assign unused_rd_urgent = rd_urgent;
  assign urgent_win       = 1'b0;
`endif

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // Read wins when alone, when write was granted last, or when urgent (feature build only).
  assign grant_rd = rd_req && (!wr_req || last_wr_q || urgent_win);

  // Next-state: arbitration, capture, busy timeout and gap timing.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    write_d   = write_q;
    addr_d    = addr_q;
    len_d     = len_q;
    err_d     = err_q;
    start_d   = 1'b0;
    cnt_d     = cnt_q;
    if (!init_done) begin
      // Losing init aborts whatever is in flight; no done pulse is produced.
      state_d = StInit;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StInit: state_d = StIdle;
        StIdle: begin
          if (rd_req || wr_req) begin
            write_d   = !grant_rd;
            last_wr_d = !grant_rd;
            addr_d    = grant_rd ? rd_addr : wr_addr;
            len_d     = grant_rd ? rd_len : wr_len;
            state_d   = StIssue;
          end
        end
        StIssue: begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = StBusy;
        end
        StBusy: begin
          if (eng_done) begin
            cnt_d   = '0;
            state_d = StGap;
          end else if (cnt_q >= BusyLast) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = StGap;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StGap: begin
          if (cnt_q >= GapLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  // State and captured-transaction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StInit;
      last_wr_q <= 1'b1;
      write_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      err_q     <= err_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs: acks show during ISSUE; done pulses qualify eng_done combinationally in BUSY.
  always_comb begin
    eng_busy    = (state_q == StBusy);
    eng_start   = start_q;
    eng_write   = write_q;
    eng_addr    = addr_q;
    eng_len     = len_q;
    err_timeout = err_q;
    rd_ack      = (state_q == StIssue) && !write_q;
    wr_ack      = (state_q == StIssue) && write_q;
    rd_done     = eng_busy && eng_done && init_done && !write_q;
    wr_done     = eng_busy && eng_done && init_done && write_q;
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed scenarios plus randomized transactions checked against a
// transaction-level model of the grant order and the cycle timing of ack/start/done/gap.
module tb_psram_arbiter;

  localparam int unsigned ADDR_W     = 22;
  localparam int unsigned LEN_W      = 6;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned TIMEOUT    = 1023;

`ifdef PSRAM_ARB_URGENT_EN
  localparam bit UrgentEn = 1'b1;
`else
  localparam bit UrgentEn = 1'b0;
`endif

  logic              clk, reset, init_done;
  logic              rd_req, rd_urgent, rd_ack, rd_done;
  logic [ADDR_W-1:0] rd_addr, wr_addr, eng_addr;
  logic [LEN_W-1:0]  rd_len, wr_len, eng_len;
  logic              wr_req, wr_ack, wr_done;
  logic              eng_start, eng_write, eng_done, eng_busy, err_timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit model_last_wr;

  psram_arbiter #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_len     (rd_len),
    .rd_urgent  (rd_urgent),
    .rd_ack     (rd_ack),
    .rd_done    (rd_done),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_len     (wr_len),
    .wr_ack     (wr_ack),
    .wr_done    (wr_done),
    .eng_start  (eng_start),
    .eng_write  (eng_write),
    .eng_addr   (eng_addr),
    .eng_len    (eng_len),
    .eng_done   (eng_done),
    .eng_busy   (eng_busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Grant rule: a lone requester wins; contested goes to the side not granted last, unless an
  // urgent read is allowed to jump the queue.
  function automatic bit model_pick(input bit r, input bit w, input bit u);
    if (r && w) return model_last_wr || (UrgentEn && u);
    return r;
  endfunction

  // From an IDLE cycle: request, expect ack next cycle and start the cycle after.
  task automatic issue_txn(input bit rq_rd, input bit rq_wr, input bit urg,
                           input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa,
                           input logic [LEN_W-1:0] rl, input logic [LEN_W-1:0] wl,
                           output bit exp_rd);
    rd_req = rq_rd; wr_req = rq_wr; rd_urgent = urg;
    rd_addr = ra; wr_addr = wa; rd_len = rl; wr_len = wl;
    exp_rd = model_pick(rq_rd, rq_wr, urg);
    model_last_wr = !exp_rd;
    tick();
    rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
    #1;
    chk("ack_rd", 32'(rd_ack), 32'(exp_rd));
    chk("ack_wr", 32'(wr_ack), 32'(!exp_rd));
    tick();
    #1;
    chk("start", 32'(eng_start), 32'd1);
    chk("busy", 32'(eng_busy), 32'd1);
    chk("write", 32'(eng_write), 32'(!exp_rd));
    chk("addr", 32'(eng_addr), 32'(exp_rd ? ra : wa));
    chk("len", 32'(eng_len), 32'(exp_rd ? rl : wl));
  endtask

  // From the start cycle: eng_done after d more cycles, then the gap, ending in an IDLE cycle.
  task automatic finish_txn(input bit exp_rd, input int unsigned d);
    for (int unsigned i = 0; i <= d; i++) begin
      if (i != 0) tick();
      eng_done = (i == d);
      #1;
      chk("start_pulse", 32'(eng_start), 32'(i == 0));
      chk("busy_hold", 32'(eng_busy), 32'd1);
      chk("rd_done", 32'(rd_done), 32'((i == d) && exp_rd));
      chk("wr_done", 32'(wr_done), 32'((i == d) && !exp_rd));
    end
    for (int unsigned i = 0; i <= GAP_CYCLES; i++) begin
      tick();
      eng_done = 1'($urandom_range(0, 1));
      #1;
      chk("gap_busy", 32'(eng_busy), 32'd0);
      chk("gap_done", 32'(rd_done | wr_done), 32'd0);
      chk("gap_ack", 32'(rd_ack | wr_ack), 32'd0);
    end
    eng_done = 1'b0;
  endtask

  task automatic run_txn(input bit rq_rd, input bit rq_wr, input bit urg, input int unsigned d,
                         input bit zero_len);
    logic [ADDR_W-1:0] ra, wa;
    logic [LEN_W-1:0]  rl, wl;
    bit                exp_rd;
    ra = ADDR_W'($urandom);
    wa = ADDR_W'($urandom);
    rl = zero_len ? '0 : LEN_W'($urandom);
    wl = zero_len ? '0 : LEN_W'($urandom);
    issue_txn(rq_rd, rq_wr, urg, ra, wa, rl, wl, exp_rd);
    finish_txn(exp_rd, d);
  endtask

  initial begin
    int unsigned pat;
    int          busy_cycles, first_gap, t_done, s;
    bit          saw_done, err_early, found, exp_rd;

    reset = 1'b1; init_done = 1'b0; eng_done = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
    rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
    model_last_wr = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(eng_busy), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_write", 32'(eng_write), 32'd0);
    chk("rst_addr", 32'(eng_addr), 32'd0);
    chk("rst_len", 32'(eng_len), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_acks", 32'(rd_ack | wr_ack | rd_done | wr_done), 32'd0);
    reset = 1'b0;
    cyc = 0;

    // First read after init: ack at cycle 7, start at cycle 8
    rd_req = 1'b1; rd_addr = 22'h000020; rd_len = 6'd32;
    while (cyc < 5) begin
      tick();
      #1;
      chk("init_no_ack", 32'(rd_ack | wr_ack), 32'd0);
    end
    init_done = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      #1;
      found = rd_ack;
    end
    chk("r24_ack_seen", 32'(found), 32'd1);
    chk("r24_ack_cycle", 32'(cyc), 32'd7);
    rd_req = 1'b0;
    model_last_wr = 1'b0;
    tick();
    #1;
    chk("r24_start", 32'(eng_start), 32'd1);
    chk("r24_start_cycle", 32'(cyc), 32'd8);
    chk("r24_write", 32'(eng_write), 32'd0);
    chk("r24_addr", 32'(eng_addr), 32'h20);
    chk("r24_len", 32'(eng_len), 32'd32);
    finish_txn(1'b1, 3);

    // Randomized traffic; the first round uses length 0
    for (int r = 0; r < 16; r++) begin
      pat = $urandom_range(1, 3);
      run_txn(pat[0], pat[1], 1'($urandom_range(0, 1)), $urandom_range(0, 5), r == 0);
    end

    // Urgent read after a read grant
    run_txn(1'b1, 1'b0, 1'b0, 2, 1'b0);
    run_txn(1'b1, 1'b1, 1'b1, 2, 1'b0);

    // init_done dropped during GAP holds off a waiting write
    run_txn(1'b1, 1'b0, 1'b0, 0, 1'b0);
    issue_txn(1'b1, 1'b0, 1'b0, 22'h1234, 22'h0, 6'd4, 6'd0, exp_rd);
    eng_done = 1'b1;
    #1;
    chk("r29_rd_done", 32'(rd_done), 32'd1);
    tick();
    eng_done = 1'b0; init_done = 1'b0; wr_req = 1'b1; wr_addr = 22'h2aaaa; wr_len = 6'd9;
    repeat (8) begin
      tick();
      #1;
      chk("r29_no_ack", 32'(wr_ack), 32'd0);
    end
    init_done = 1'b1;
    tick();
    #1;
    chk("r29_no_ack_idle", 32'(wr_ack), 32'd0);
    tick();
    #1;
    chk("r29_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    model_last_wr = 1'b1;
    tick();
    #1;
    chk("r29_start", 32'(eng_start), 32'd1);
    chk("r29_write", 32'(eng_write), 32'd1);
    chk("r29_addr", 32'(eng_addr), 32'h2aaaa);
    finish_txn(1'b0, 1);

    // Busy timeout: exactly TIMEOUT busy cycles, no done pulse, sticky error
    issue_txn(1'b0, 1'b1, 1'b0, 22'h0, 22'h155, 6'd7, 6'd7, exp_rd);
    busy_cycles = 1; saw_done = 1'b0; err_early = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 20 && eng_busy; i++) begin
      tick();
      #1;
      if (eng_busy) busy_cycles++;
      if (eng_busy && err_timeout) err_early = 1'b1;
      saw_done = saw_done | rd_done | wr_done;
    end
    chk("r27_busy_cycles", 32'(busy_cycles), 32'(TIMEOUT));
    chk("r27_err", 32'(err_timeout), 32'd1);
    chk("r27_err_early", 32'(err_early), 32'd0);
    chk("r27_no_done", 32'(saw_done), 32'd0);
    first_gap = cyc;
    rd_req = 1'b1; rd_addr = 22'h3ff00; rd_len = 6'd1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      #1;
      found = rd_ack;
    end
    chk("r27_ack_seen", 32'(found), 32'd1);
    chk("r27_gap_len", 32'(cyc - first_gap), 32'(GAP_CYCLES + 1));
    rd_req = 1'b0;
    model_last_wr = 1'b0;
    tick();
    #1;
    chk("r27_start", 32'(eng_start), 32'd1);
    finish_txn(1'b1, 2);
    chk("r27_err_sticky", 32'(err_timeout), 32'd1);

    // Reset in the middle of BUSY
    issue_txn(1'b1, 1'b0, 1'b0, 22'h777, 22'h0, 6'd3, 6'd0, exp_rd);
    repeat (3) tick();
    reset = 1'b1; eng_done = 1'b1;
    #1;
    chk("r28_busy", 32'(eng_busy), 32'd0);
    chk("r28_done", 32'(rd_done | wr_done), 32'd0);
    chk("r28_err", 32'(err_timeout), 32'd0);
    tick();
    reset = 1'b0; eng_done = 1'b0;
    model_last_wr = 1'b1;

    // Both held continuously: R,W,R,W with GAP_CYCLES+2 from eng_done to the next ack
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 22'h0abcd; wr_addr = 22'h3dcba; rd_len = 6'd16; wr_len = 6'd8;
    t_done = 0;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        tick();
        #1;
        found = rd_ack | wr_ack;
      end
      exp_rd = model_pick(1'b1, 1'b1, 1'b0);
      model_last_wr = !exp_rd;
      chk("r25_ack_seen", 32'(found), 32'd1);
      chk("r25_rd_ack", 32'(rd_ack), 32'(exp_rd));
      chk("r25_order", 32'(rd_ack), 32'(g % 2 == 0));
      if (g > 0) chk("r25_gap", 32'(cyc - t_done), 32'(GAP_CYCLES + 2));
      if (g == 3) begin
        rd_req = 1'b0; wr_req = 1'b0;
      end
      tick();
      #1;
      chk("r25_start", 32'(eng_start), 32'd1);
      s = cyc;
      repeat (10) tick();
      eng_done = 1'b1;
      #1;
      chk("r25_start_to_done", 32'(cyc - s), 32'd10);
      chk("r25_rd_done", 32'(rd_done), 32'(exp_rd));
      chk("r25_wr_done", 32'(wr_done), 32'(!exp_rd));
      t_done = cyc;
      tick();
      eng_done = 1'b0;
    end
    repeat (GAP_CYCLES + 2) begin
      tick();
      #1;
      chk("end_no_ack", 32'(rd_ack | wr_ack), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
